// File: rtl/uart_baud_gen.sv
// Fractional baud-rate tick generator: 16x oversample strobe (baud_clock) and
// 1x bit strobe (xmit_pulse), with optional 1/8-step fractional stretching.
module uart_baud_gen #(
  parameter bit BAUD_VAL_FRCTN_EN = 1'b0
) (
  input  logic        PCLK,
  input  logic        aresetn,
  input  logic [12:0] baud_val,
  input  logic [2:0]  baud_val_fraction,
  output logic        baud_clock,
  output logic        xmit_pulse
);

  logic [12:0] cnt;
  logic [2:0]  frac_idx;
  logic        ext_done;
  logic [3:0]  xcnt;

  logic        need_ext;
  logic        tick_event;

  // Ticks whose index falls below the fraction get one extra PCLK, spreading
  // the fractional remainder evenly over each group of eight ticks.
  assign need_ext   = BAUD_VAL_FRCTN_EN && (frac_idx < baud_val_fraction);
  assign tick_event = (cnt == 13'd0) && !(need_ext && !ext_done);

  // NOTE: every register here is sequential state, so it uses non-blocking
  // assignments and is cleared by the asynchronous reset.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt        <= 13'd0;
      frac_idx   <= 3'd0;
      ext_done   <= 1'b0;
      xcnt       <= 4'd0;
      baud_clock <= 1'b0;
      xmit_pulse <= 1'b0;
    end else begin
      if (cnt != 13'd0) begin
        cnt <= cnt - 13'd1;
      end else if (need_ext && !ext_done) begin
        ext_done <= 1'b1;
      end else begin
        // baud_val is only sampled here, so mid-count changes apply at reload.
        cnt      <= baud_val;
        ext_done <= 1'b0;
        frac_idx <= frac_idx + 3'd1;
        xcnt     <= xcnt + 4'd1;
      end
      baud_clock <= tick_event;
      xmit_pulse <= tick_event && (xcnt == 4'd15);
    end
  end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Fractional baud-rate tick generator feeding the transmitter and receiver in the UART core; sits directly downstream of the APB register wrapper, consuming its `baud_val` and `baud_val_fraction` outputs. Produces a one-PCLK-wide 16x-oversample strobe (`baud_clock`) for the receiver sampler and a 1x bit strobe (`xmit_pulse`) for the transmitter. Fractional mode stretches selected tick periods by one PCLK so the average divide ratio is `baud_val + 1 + fraction/8`.

## Interface
- BAUD_VAL_FRCTN_EN, 0, 1 = honour `baud_val_fraction`; 0 = fraction input ignored (treated as 0)
- PCLK  in  1  system clock; all logic rising-edge
- aresetn  in  1  reset aresetn, asynchronous, active-low; clock PCLK
- baud_val  in  13  integer divider; tick period = baud_val+1 PCLK cycles
- baud_val_fraction  in  3  fractional eighths added to the divider (0..7)
- baud_clock  out  1  16x oversample strobe, one PCLK wide, registered
- xmit_pulse  out  1  bit-rate strobe, every 16th baud_clock, one PCLK wide, registered

## Operation
- State: `cnt[12:0]` down-counter, `frac_idx[2:0]` tick index, `ext_done` extension flag, `xcnt[3:0]` tick counter.
- `need_ext = BAUD_VAL_FRCTN_EN && (frac_idx < baud_val_fraction)`; unsigned 3-bit compare.
- Each PCLK edge:
  - cnt != 0: cnt <= cnt-1; no tick.
  - cnt == 0 and need_ext and !ext_done: ext_done <= 1; cnt holds 0; no tick (inserted cycle).
  - cnt == 0 otherwise: tick_event; cnt <= baud_val; ext_done <= 0; frac_idx <= frac_idx+1 (wraps 7->0); xcnt <= xcnt+1 (wraps 15->0).
- baud_clock <= tick_event; xmit_pulse <= tick_event && (xcnt == 15).
- The net effect is a period of baud_val+1 for ticks with frac_idx >= fraction and baud_val+2 for ticks with frac_idx < fraction. Over any 8 consecutive ticks starting at frac_idx 0, the total is 8*(baud_val+1)+fraction cycles.
- `baud_val` and `baud_val_fraction` are sampled only at reload (tick_event) and in the need_ext check. A change mid-count takes effect at the next reload; there is no counter restart.
- baud_val == 0 with no extension: tick every cycle, so baud_clock is held high continuously; xmit_pulse is high 1 in 16 cycles.
- Inputs are assumed stable/synchronous to PCLK (driven by wrapper registers); no synchronisers.

## Timing
- Reset (aresetn low, asynchronous): cnt=0, frac_idx=0, ext_done=0, xcnt=0, baud_clock=0, xmit_pulse=0.
- First edge after release:
  - fraction=0 or BAUD_VAL_FRCTN_EN=0: tick_event occurs; baud_clock is high in cycle 1 after release.
  - frac_idx=0 < fraction: an extension is inserted first; baud_clock is high in cycle 2.
- Latency from tick_event to output: 1 PCLK (registered outputs).
- xmit_pulse is always coincident with a baud_clock pulse; first xmit_pulse occurs on the 16th baud_clock after reset.
- Reset asserted mid-count: all state clears immediately; outputs go low asynchronously; no partial pulse after release.
- No handshake; consumers sample strobes on the same PCLK edge.

## Test plan
- baud_val=3, fraction=0, EN=0: baud_clock pulses every 4 cycles, first in cycle 1 after release; xmit_pulse every 64 cycles, coincident with the 16th baud_clock.
- baud_val=3, fraction=4, EN=1: tick periods 5,5,5,5,4,4,4,4 repeating, 36 cycles per 8 ticks; first baud_clock in cycle 2.
- baud_val=3, fraction=7, EN=0: fraction ignored, period fixed at 4; with EN=1 the periods are 5×7 then 4, totalling 39 per 8 ticks.
- baud_val=0, fraction=0: baud_clock constantly 1 after cycle 1; xmit_pulse 1 every 16th cycle. With EN=1 and fraction=1: one low gap per 8 ticks.
- Change baud_val 9->2 mid-count (cnt=5): current period completes at 10 cycles; following periods are 3.
- Assert aresetn mid-period with xcnt=10: outputs are 0 immediately. After release, the baud_clock/xmit_pulse sequence restarts exactly as from power-on (xmit_pulse on the 16th tick).
